// File: rtl/rsa_stream_ctrl_if.sv
// Byte-link bundle for rsa_stream_ctrl.
// Carries the host rx and tx valid/ready channels.
interface rsa_stream_ctrl_if;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_rx_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_ready,
    output o_rx_ready, o_tx_data, o_tx_valid
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_ready,
    input  o_rx_ready, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front end for the RSA256 core.
// Loads N, d, a big-endian, starts the core, streams the result out.
module rsa_stream_ctrl #(
  parameter int OUT_BYTES = 31
) (
  input  logic                i_clk,
  input  logic                i_rst,
  rsa_stream_ctrl_if.slave    bus,
  input  logic                i_key_keep,
  output logic                o_core_start,
  output logic [255:0]        o_core_n,
  output logic [255:0]        o_core_d,
  output logic [255:0]        o_core_a,
  input  logic [255:0]        i_core_a_pow_d,
  input  logic                i_core_finished,
  output logic                o_busy
);

  localparam int         TOP     = 8 * OUT_BYTES - 1;
  localparam logic [4:0] LAST_TX = 5'(OUT_BYTES - 1);

  typedef enum logic [2:0] {
    S_GET_N, S_GET_D, S_GET_A,
    S_START, S_WAIT, S_SEND
  } state_e;

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [255:0] n_q, n_d;
  logic [255:0] d_q, d_d;
  logic [255:0] a_q, a_d;
  logic [255:0] tx_sh_q, tx_sh_d;
  logic         rx_ready_q, rx_ready_d;
  logic         tx_valid_q, tx_valid_d;
  logic         start_q, start_d;
  logic         busy_q, busy_d;
  logic         rx_fire, tx_fire;

  assign rx_fire = rx_ready_q && bus.i_rx_valid;
  assign tx_fire = tx_valid_q && bus.i_tx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    a_d     = a_q;
    tx_sh_d = tx_sh_q;
    unique case (state_q)
      S_GET_N, S_GET_D, S_GET_A: begin
        if (rx_fire) begin
          cnt_d = cnt_q + 5'd1;
          unique case (state_q)
            S_GET_N: n_d = {n_q[247:0], bus.i_rx_data};
            S_GET_D: d_d = {d_q[247:0], bus.i_rx_data};
            default: a_d = {a_q[247:0], bus.i_rx_data};
          endcase
          if (cnt_q == 5'd31) begin
            unique case (state_q)
              S_GET_N: state_d = S_GET_D;
              S_GET_D: state_d = S_GET_A;
              default: state_d = S_START;
            endcase
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_core_finished) begin
          tx_sh_d = i_core_a_pow_d;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_fire) begin
          tx_sh_d = tx_sh_q << 8;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == LAST_TX) begin
            cnt_d   = 5'd0;
            state_d = i_key_keep ? S_GET_A : S_GET_N;
          end
        end
      end
      default: state_d = S_GET_N;
    endcase
    // Outputs are registered from the next state so they line up with it.
    rx_ready_d = (state_d == S_GET_N) || (state_d == S_GET_D) ||
                 (state_d == S_GET_A);
    tx_valid_d = (state_d == S_SEND);
    start_d    = (state_d == S_START);
    busy_d     = (state_d == S_START) || (state_d == S_WAIT) ||
                 (state_d == S_SEND);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_GET_N;
      cnt_q      <= '0;
      n_q        <= '0;
      d_q        <= '0;
      a_q        <= '0;
      tx_sh_q    <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      d_q        <= d_d;
      a_q        <= a_d;
      tx_sh_q    <= tx_sh_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_rx_ready = rx_ready_q;
  assign bus.o_tx_valid = tx_valid_q;
  assign bus.o_tx_data  = tx_valid_q ? tx_sh_q[TOP -: 8] : 8'h00;
  assign o_core_start   = start_q;
  assign o_core_n       = n_q;
  assign o_core_d       = d_q;
  assign o_core_a       = a_q;
  assign o_busy         = busy_q;

endmodule
